// File: rtl/morse_pkg.sv
// Shared types, character codes and the Morse pattern table for the key decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    localparam logic [5:0] CODE_INVALID     = 6'd63;
    localparam logic [5:0] CODE_DIGIT_BASE  = 6'd0;
    localparam logic [5:0] CODE_LETTER_BASE = 6'd10;

    // bits: LSB is the first symbol sent, 1 = dash; unused upper bits are zero.
    function automatic logic [5:0] morse_lookup(input logic [2:0] len, input logic [4:0] bits);
        logic [5:0] code;
        code = CODE_INVALID;
        case ({len, bits})
            {3'd2, 5'd2}:  code = CODE_LETTER_BASE + 6'd0;
            {3'd4, 5'd1}:  code = CODE_LETTER_BASE + 6'd1;
            {3'd4, 5'd5}:  code = CODE_LETTER_BASE + 6'd2;
            {3'd3, 5'd1}:  code = CODE_LETTER_BASE + 6'd3;
            {3'd1, 5'd0}:  code = CODE_LETTER_BASE + 6'd4;
            {3'd4, 5'd4}:  code = CODE_LETTER_BASE + 6'd5;
            {3'd3, 5'd3}:  code = CODE_LETTER_BASE + 6'd6;
            {3'd4, 5'd0}:  code = CODE_LETTER_BASE + 6'd7;
            {3'd2, 5'd0}:  code = CODE_LETTER_BASE + 6'd8;
            {3'd4, 5'd14}: code = CODE_LETTER_BASE + 6'd9;
            {3'd3, 5'd5}:  code = CODE_LETTER_BASE + 6'd10;
            {3'd4, 5'd2}:  code = CODE_LETTER_BASE + 6'd11;
            {3'd2, 5'd3}:  code = CODE_LETTER_BASE + 6'd12;
            {3'd2, 5'd1}:  code = CODE_LETTER_BASE + 6'd13;
            {3'd3, 5'd7}:  code = CODE_LETTER_BASE + 6'd14;
            {3'd4, 5'd6}:  code = CODE_LETTER_BASE + 6'd15;
            {3'd4, 5'd11}: code = CODE_LETTER_BASE + 6'd16;
            {3'd3, 5'd2}:  code = CODE_LETTER_BASE + 6'd17;
            {3'd3, 5'd0}:  code = CODE_LETTER_BASE + 6'd18;
            {3'd1, 5'd1}:  code = CODE_LETTER_BASE + 6'd19;
            {3'd3, 5'd4}:  code = CODE_LETTER_BASE + 6'd20;
            {3'd4, 5'd8}:  code = CODE_LETTER_BASE + 6'd21;
            {3'd3, 5'd6}:  code = CODE_LETTER_BASE + 6'd22;
            {3'd4, 5'd9}:  code = CODE_LETTER_BASE + 6'd23;
            {3'd4, 5'd13}: code = CODE_LETTER_BASE + 6'd24;
            {3'd4, 5'd3}:  code = CODE_LETTER_BASE + 6'd25;
            {3'd5, 5'd31}: code = CODE_DIGIT_BASE + 6'd0;
            {3'd5, 5'd30}: code = CODE_DIGIT_BASE + 6'd1;
            {3'd5, 5'd28}: code = CODE_DIGIT_BASE + 6'd2;
            {3'd5, 5'd24}: code = CODE_DIGIT_BASE + 6'd3;
            {3'd5, 5'd16}: code = CODE_DIGIT_BASE + 6'd4;
            {3'd5, 5'd0}:  code = CODE_DIGIT_BASE + 6'd5;
            {3'd5, 5'd1}:  code = CODE_DIGIT_BASE + 6'd6;
            {3'd5, 5'd3}:  code = CODE_DIGIT_BASE + 6'd7;
            {3'd5, 5'd7}:  code = CODE_DIGIT_BASE + 6'd8;
            {3'd5, 5'd15}: code = CODE_DIGIT_BASE + 6'd9;
            default:       code = CODE_INVALID;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Free-running divider producing a one-cycle timing tick every TICK_DIV clocks.
module morse_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/morse_key_decoder.sv
// Telegraph key timing decoder: classifies presses into dots/dashes and
// assembles letters into an 8-entry character buffer.
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int MIN_T     = 20,
    parameter int DOT_MAX_T = 200,
    parameter int LETTER_T  = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_in,
    input  logic        backspace,
    input  logic        clear,
    output logic [4:0]  sym_bits,
    output logic [2:0]  sym_cnt,
    output logic        char_valid,
    output logic [5:0]  char_code,
    output logic [47:0] chars,
    output logic [3:0]  char_cnt,
    output logic        err,
    output logic        sidetone
);
    localparam logic [11:0] MIN_TC      = 12'(MIN_T);
    localparam logic [11:0] DOT_MAX_TC  = 12'(DOT_MAX_T);
    localparam logic [11:0] LETTER_TC   = 12'(LETTER_T);
    localparam logic [11:0] DUR_SAT     = 12'hFFF;

    logic tick;

    state_t      state_q, state_d;
    logic        prev_space_q, prev_space_d;
    logic [11:0] dur_q, dur_d;
    logic        key_q, key_d;
    logic [4:0]  sym_bits_q, sym_bits_d;
    logic [2:0]  sym_cnt_q, sym_cnt_d;
    logic        ovf_q, ovf_d;
    logic        char_valid_q, char_valid_d;
    logic [5:0]  char_code_q, char_code_d;
    logic [47:0] chars_q, chars_d;
    logic [3:0]  char_cnt_q, char_cnt_d;
    logic        err_q, err_d;
    logic        emit;
    logic [5:0]  new_code;

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .tick (tick)
    );

    always_comb begin
        state_d      = state_q;
        prev_space_d = prev_space_q;
        dur_d        = dur_q;
        key_d        = key_in;
        sym_bits_d   = sym_bits_q;
        sym_cnt_d    = sym_cnt_q;
        ovf_d        = ovf_q;
        char_valid_d = 1'b0;
        char_code_d  = char_code_q;
        chars_d      = chars_q;
        char_cnt_d   = char_cnt_q;
        err_d        = err_q;
        emit         = 1'b0;
        new_code     = ovf_q ? CODE_INVALID : morse_lookup(sym_cnt_q, sym_bits_q);

        // One counter times both marks and gaps: every key edge restarts it.
        if (key_in != key_q)                  dur_d = '0;
        else if (tick && dur_q != DUR_SAT)    dur_d = dur_q + 12'd1;

        case (state_q)
            ST_IDLE: begin
                if (key_in) begin
                    state_d      = ST_MARK;
                    prev_space_d = 1'b0;
                end
            end
            ST_MARK: begin
                if (!key_in) begin
                    if (dur_q < MIN_TC) begin
                        state_d = prev_space_q ? ST_SPACE : ST_IDLE;
                    end else begin
                        state_d = ST_SPACE;
                        if (sym_cnt_q == 3'd5) begin
                            ovf_d = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            sym_bits_d[sym_cnt_q] = (dur_q >= DOT_MAX_TC);
                            sym_cnt_d             = sym_cnt_q + 3'd1;
                        end
                    end
                end
            end
            ST_SPACE: begin
                if (key_in) begin
                    state_d      = ST_MARK;
                    prev_space_d = 1'b1;
                end else if (dur_q == LETTER_TC) begin
                    emit = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            char_valid_d = 1'b1;
            char_code_d  = new_code;
            chars_d      = {chars_q[41:0], new_code};
            if (char_cnt_q != 4'd8)       char_cnt_d = char_cnt_q + 4'd1;
            if (new_code == CODE_INVALID) err_d = 1'b1;
            sym_bits_d = '0;
            sym_cnt_d  = '0;
            ovf_d      = 1'b0;
            state_d    = ST_IDLE;
        end

        // An emit only happens with symbols pending, so backspace always cancels it.
        if (backspace) begin
            if (sym_cnt_q != 3'd0) begin
                char_valid_d = 1'b0;
                char_code_d  = char_code_q;
                chars_d      = chars_q;
                char_cnt_d   = char_cnt_q;
                sym_bits_d   = '0;
                sym_cnt_d    = '0;
                ovf_d        = 1'b0;
                state_d      = ST_IDLE;
            end else if (char_cnt_q != 4'd0) begin
                chars_d    = {6'd0, chars_q[47:6]};
                char_cnt_d = char_cnt_q - 4'd1;
            end
        end

        if (clear) begin
            state_d      = ST_IDLE;
            prev_space_d = 1'b0;
            dur_d        = '0;
            key_d        = 1'b0;
            sym_bits_d   = '0;
            sym_cnt_d    = '0;
            ovf_d        = 1'b0;
            char_valid_d = 1'b0;
            char_code_d  = '0;
            chars_d      = '0;
            char_cnt_d   = '0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            prev_space_q <= 1'b0;
            dur_q        <= '0;
            key_q        <= 1'b0;
            sym_bits_q   <= '0;
            sym_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            char_valid_q <= 1'b0;
            char_code_q  <= '0;
            chars_q      <= '0;
            char_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_space_q <= prev_space_d;
            dur_q        <= dur_d;
            key_q        <= key_d;
            sym_bits_q   <= sym_bits_d;
            sym_cnt_q    <= sym_cnt_d;
            ovf_q        <= ovf_d;
            char_valid_q <= char_valid_d;
            char_code_q  <= char_code_d;
            chars_q      <= chars_d;
            char_cnt_q   <= char_cnt_d;
            err_q        <= err_d;
        end
    end

    assign sym_bits   = sym_bits_q;
    assign sym_cnt    = sym_cnt_q;
    assign char_valid = char_valid_q;
    assign char_code  = char_code_q;
    assign chars      = chars_q;
    assign char_cnt   = char_cnt_q;
    assign err        = err_q;
    assign sidetone   = key_q;
endmodule

// File: tb/tb_morse_key_decoder.sv
// Self-checking bench for morse_key_decoder against a string-table Morse model.
`timescale 1ns/1ps
module tb_morse_key_decoder;
    localparam int TICK_DIV  = 1;
    localparam int MIN_T     = 2;
    localparam int DOT_MAX_T = 5;
    localparam int LETTER_T  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_in = 1'b0;
    logic        backspace = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  sym_bits;
    logic [2:0]  sym_cnt;
    logic        char_valid;
    logic [5:0]  char_code;
    logic [47:0] chars;
    logic [3:0]  char_cnt;
    logic        err;
    logic        sidetone;

    int errors = 0;
    int checks = 0;
    string tbl [36];
    int model_q [$];

    always #5 clk = ~clk;

    morse_key_decoder #(
        .TICK_DIV(TICK_DIV), .MIN_T(MIN_T), .DOT_MAX_T(DOT_MAX_T), .LETTER_T(LETTER_T)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .backspace(backspace), .clear(clear),
        .sym_bits(sym_bits), .sym_cnt(sym_cnt), .char_valid(char_valid),
        .char_code(char_code), .chars(chars), .char_cnt(char_cnt),
        .err(err), .sidetone(sidetone)
    );

    // Code of a dot/dash string: its table index, or 63 if unknown/too long.
    function automatic int model_code(input string pat);
        if (pat.len() > 5) return 63;
        for (int i = 0; i < 36; i++) if (tbl[i] == pat) return i;
        return 63;
    endfunction

    function automatic void model_push(input int code);
        model_q.push_front(code);
        if (model_q.size() > 8) void'(model_q.pop_back());
    endfunction

    function automatic logic [47:0] model_packed();
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < model_q.size(); i++) r[i*6 +: 6] = 6'(model_q[i]);
        return r;
    endfunction

    // A press held n cycles measures n-1 ticks (the edge cycle restarts the count).
    task automatic press(input int n);
        key_in = 1'b1;
        repeat (n) @(negedge clk);
        key_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic gap(input int m);
        repeat (m) @(negedge clk);
    endtask

    task automatic send_pattern(input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == "-") press($urandom_range(6, 12));
            else               press($urandom_range(3, 5));
            if (i != pat.len() - 1) gap($urandom_range(0, 6));
        end
    endtask

    task automatic wait_emit(input int bound, output bit got, output logic [5:0] code, output int lat);
        got = 1'b0; code = '0; lat = 0;
        for (int i = 1; i <= bound && !got; i++) begin
            @(negedge clk);
            if (char_valid === 1'b1) begin
                got = 1'b1; code = char_code; lat = i;
            end
        end
    endtask

    task automatic pulse_bs();
        backspace = 1'b1;
        @(negedge clk);
        backspace = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone} !== '0) begin
            errors++; $display("FAIL reset_low: outputs=%h expected all zero",
                {sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone} !== '0) begin
            errors++; $display("FAIL reset_release: outputs=%h expected all zero",
                {sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone});
        end
    endtask

    task automatic test_letter_e();
        bit got; logic [5:0] code; int lat;
        do_clear();
        press(3);
        wait_emit(40, got, code, lat);
        checks++;
        if (!got || code !== 6'd14) begin
            errors++; $display("FAIL letter_e_code: got=%0d seen=%0d expected=14", code, got);
        end
        checks++;
        if (lat != LETTER_T + 1) begin
            errors++; $display("FAIL letter_e_latency: got=%0d expected=%0d", lat, LETTER_T + 1);
        end
        checks++;
        if (char_cnt !== 4'd1 || chars[5:0] !== 6'd14) begin
            errors++; $display("FAIL letter_e_buffer: cnt=%0d chars0=%0d expected cnt=1 chars0=14", char_cnt, chars[5:0]);
        end
        model_push(14);
        @(negedge clk);
        checks++;
        if (char_valid !== 1'b0 || char_code !== 6'd14) begin
            errors++; $display("FAIL letter_e_pulse: valid=%0b code=%0d expected valid=0 code=14", char_valid, char_code);
        end
    endtask

    task automatic test_letter_k();
        bit got; logic [5:0] code; int lat;
        do_clear();
        press(6); gap(3); press(3); gap(3); press(6);
        checks++;
        if (sym_cnt !== 3'd3 || sym_bits !== 5'b00101) begin
            errors++; $display("FAIL letter_k_pending: cnt=%0d bits=%b expected cnt=3 bits=00101", sym_cnt, sym_bits);
        end
        wait_emit(40, got, code, lat);
        checks++;
        if (!got || code !== 6'd20) begin
            errors++; $display("FAIL letter_k_code: got=%0d seen=%0d expected=20", code, got);
        end
    endtask

    task automatic test_boundary();
        bit got; logic [5:0] code; int lat;
        do_clear();
        press(DOT_MAX_T);
        checks++;
        if (sym_cnt !== 3'd1 || sym_bits !== 5'b00000) begin
            errors++; $display("FAIL boundary_dot: cnt=%0d bits=%b expected cnt=1 bits=00000", sym_cnt, sym_bits);
        end
        gap(2);
        press(DOT_MAX_T + 1);
        checks++;
        if (sym_cnt !== 3'd2 || sym_bits !== 5'b00010) begin
            errors++; $display("FAIL boundary_dash: cnt=%0d bits=%b expected cnt=2 bits=00010", sym_cnt, sym_bits);
        end
        wait_emit(40, got, code, lat);
        checks++;
        if (!got || code !== 6'(model_code(".-"))) begin
            errors++; $display("FAIL boundary_letter_a: got=%0d seen=%0d expected=%0d", code, got, model_code(".-"));
        end
        press(4200);
        wait_emit(40, got, code, lat);
        checks++;
        if (!got || code !== 6'(model_code("-"))) begin
            errors++; $display("FAIL saturated_dash: got=%0d seen=%0d expected=%0d", code, got, model_code("-"));
        end
    endtask

    task automatic test_overflow();
        bit got; logic [5:0] code; int lat;
        do_clear();
        for (int i = 0; i < 5; i++) begin press(7); gap(2); end
        wait_emit(40, got, code, lat);
        checks++;
        if (!got || code !== 6'd0 || err !== 1'b0) begin
            errors++; $display("FAIL five_dashes: got=%0d seen=%0d err=%0b expected code=0 err=0", code, got, err);
        end
        for (int i = 0; i < 6; i++) begin press(7); gap(2); end
        wait_emit(40, got, code, lat);
        checks++;
        if (!got || code !== 6'd63 || err !== 1'b1) begin
            errors++; $display("FAIL six_dashes: got=%0d seen=%0d err=%0b expected code=63 err=1", code, got, err);
        end
        checks++;
        if (char_cnt !== 4'd2 || chars[11:0] !== {6'd0, 6'd63}) begin
            errors++; $display("FAIL overflow_buffer: cnt=%0d chars=%h expected cnt=2 chars[11:0]=03f", char_cnt, chars[11:0]);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_q.delete();
        checks++;
        if ({sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone} !== '0) begin
            errors++; $display("FAIL clear_flush: outputs=%h expected all zero",
                {sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone});
        end
    endtask

    task automatic test_glitch();
        bit got; logic [5:0] code; int lat;
        do_clear();
        key_in = 1'b1;
        #1;
        checks++;
        if (sidetone !== 1'b0) begin
            errors++; $display("FAIL sidetone_lag: got=%0b expected=0", sidetone);
        end
        @(negedge clk);
        checks++;
        if (sidetone !== 1'b1) begin
            errors++; $display("FAIL sidetone_follow: got=%0b expected=1", sidetone);
        end
        key_in = 1'b0;
        @(negedge clk);
        wait_emit(25, got, code, lat);
        checks++;
        if (sym_cnt !== 3'd0 || got) begin
            errors++; $display("FAIL glitch_ignored: cnt=%0d emitted=%0d expected cnt=0 emitted=0", sym_cnt, got);
        end
        press(3); gap(3); press(1);
        wait_emit(40, got, code, lat);
        checks++;
        if (!got || code !== 6'd14 || lat != LETTER_T + 1) begin
            errors++; $display("FAIL glitch_gap_restart: got=%0d seen=%0d lat=%0d expected code=14 lat=%0d", code, got, lat, LETTER_T + 1);
        end
    endtask

    task automatic test_backspace();
        bit got; logic [5:0] code; int lat;
        do_clear();
        press(3); wait_emit(40, got, code, lat); model_push(model_code("."));
        press(8); wait_emit(40, got, code, lat); model_push(model_code("-"));
        pulse_bs();
        void'(model_q.pop_front());
        checks++;
        if (char_cnt !== 4'd1 || chars !== model_packed()) begin
            errors++; $display("FAIL bs_char: cnt=%0d chars=%h expected cnt=1 chars=%h", char_cnt, chars, model_packed());
        end
        press(3); gap(1); press(3);
        pulse_bs();
        wait_emit(25, got, code, lat);
        checks++;
        if (sym_cnt !== 3'd0 || got || char_cnt !== 4'd1) begin
            errors++; $display("FAIL bs_pending: cnt=%0d emitted=%0d chars=%0d expected 0 0 1", sym_cnt, got, char_cnt);
        end
        press(3);
        gap(LETTER_T);
        pulse_bs();
        wait_emit(25, got, code, lat);
        checks++;
        if (got || sym_cnt !== 3'd0 || char_cnt !== 4'd1) begin
            errors++; $display("FAIL bs_cancels_emit: emitted=%0d cnt=%0d chars=%0d expected 0 0 1", got, sym_cnt, char_cnt);
        end
        pulse_bs();
        pulse_bs();
        checks++;
        if (char_cnt !== 4'd0 || chars !== 48'd0) begin
            errors++; $display("FAIL bs_empty: cnt=%0d chars=%h expected cnt=0 chars=0", char_cnt, chars);
        end
        model_q.delete();
    endtask

    task automatic test_random_letters();
        bit got; logic [5:0] code; int lat; int idx;
        do_clear();
        for (int k = 0; k < 9; k++) begin
            idx = $urandom_range(0, 35);
            send_pattern(tbl[idx]);
            checks++;
            if (int'(sym_cnt) != tbl[idx].len()) begin
                errors++; $display("FAIL rand_pending[%0d]: cnt=%0d expected=%0d", k, sym_cnt, tbl[idx].len());
            end
            wait_emit(40, got, code, lat);
            checks++;
            if (!got || int'(code) != model_code(tbl[idx])) begin
                errors++; $display("FAIL rand_code[%0d] %s: got=%0d seen=%0d expected=%0d", k, tbl[idx], code, got, model_code(tbl[idx]));
            end
            model_push(model_code(tbl[idx]));
        end
        checks++;
        if (char_cnt !== 4'd8 || chars !== model_packed()) begin
            errors++; $display("FAIL rand_buffer: cnt=%0d chars=%h expected cnt=8 chars=%h", char_cnt, chars, model_packed());
        end
    endtask

    task automatic test_reset_mid_press();
        bit got; logic [5:0] code; int lat;
        press(3); gap(1);
        key_in = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone} !== '0) begin
            errors++; $display("FAIL reset_mid_press: outputs=%h expected all zero",
                {sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone});
        end
        @(negedge clk);
        key_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_q.delete();
        wait_emit(30, got, code, lat);
        checks++;
        if (got || {sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone} !== '0) begin
            errors++; $display("FAIL reset_after_release: emitted=%0d outputs=%h expected none and zero", got,
                {sym_bits, sym_cnt, char_valid, char_code, chars, char_cnt, err, sidetone});
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
                ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..", "--",
                "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
        test_reset();
        test_letter_e();
        test_letter_k();
        test_boundary();
        test_overflow();
        test_clear();
        test_glitch();
        test_backspace();
        test_random_letters();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
